// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse character encoder.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MARK,
        ST_ELEM_GAP,
        ST_CHAR_GAP,
        ST_WORD_GAP
    } state_t;

    localparam int ELEM_UNITS     = 1;
    localparam int DASH_UNITS     = 3;
    localparam int CHAR_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS = 4;

    // Pattern holds the code in its low `len` bits, first element in bit len-1, 1 = dash.
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pattern;
    } code_entry_t;

endpackage

// File: rtl/morse_code_rom.sv
// Combinational ASCII to Morse code lookup, folding lower case onto upper case.
module morse_code_rom
    import morse_pkg::*;
(
    input  logic [7:0]  ascii,
    output logic        valid,
    output logic        is_space,
    output code_entry_t code
);

    logic [7:0] folded;

    always_comb begin
        folded   = ascii;
        if (ascii >= 8'h61 && ascii <= 8'h7A)
            folded = ascii - 8'h20;
        valid    = 1'b1;
        is_space = 1'b0;
        code     = '0;
        case (folded)
            8'h41: code = {3'd2, 5'b00001};
            8'h42: code = {3'd4, 5'b01000};
            8'h43: code = {3'd4, 5'b01010};
            8'h44: code = {3'd3, 5'b00100};
            8'h45: code = {3'd1, 5'b00000};
            8'h46: code = {3'd4, 5'b00010};
            8'h47: code = {3'd3, 5'b00110};
            8'h48: code = {3'd4, 5'b00000};
            8'h49: code = {3'd2, 5'b00000};
            8'h4A: code = {3'd4, 5'b00111};
            8'h4B: code = {3'd3, 5'b00101};
            8'h4C: code = {3'd4, 5'b00100};
            8'h4D: code = {3'd2, 5'b00011};
            8'h4E: code = {3'd2, 5'b00010};
            8'h4F: code = {3'd3, 5'b00111};
            8'h50: code = {3'd4, 5'b00110};
            8'h51: code = {3'd4, 5'b01101};
            8'h52: code = {3'd3, 5'b00010};
            8'h53: code = {3'd3, 5'b00000};
            8'h54: code = {3'd1, 5'b00001};
            8'h55: code = {3'd3, 5'b00001};
            8'h56: code = {3'd4, 5'b00001};
            8'h57: code = {3'd3, 5'b00011};
            8'h58: code = {3'd4, 5'b01001};
            8'h59: code = {3'd4, 5'b01011};
            8'h5A: code = {3'd4, 5'b01100};
            8'h30: code = {3'd5, 5'b11111};
            8'h31: code = {3'd5, 5'b01111};
            8'h32: code = {3'd5, 5'b00111};
            8'h33: code = {3'd5, 5'b00011};
            8'h34: code = {3'd5, 5'b00001};
            8'h35: code = {3'd5, 5'b00000};
            8'h36: code = {3'd5, 5'b10000};
            8'h37: code = {3'd5, 5'b11000};
            8'h38: code = {3'd5, 5'b11100};
            8'h39: code = {3'd5, 5'b11110};
            8'h20: is_space = 1'b1;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_char_encoder.sv
// Turns accepted ASCII characters into timed Morse keying with element strobes.
module morse_char_encoder
    import morse_pkg::*;
#(
    parameter int MAX_SYMBOLS = 5,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    output logic             in_ready,
    input  logic [CNT_W-1:0] unit_cycles,
    input  logic             abort,
    output logic             key_out,
    output logic             dot_pulse,
    output logic             dash_pulse,
    output logic             busy,
    output logic             done,
    output logic             err
);

    logic internal_rst_n;
    assign internal_rst_n = rst_n;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       u_reg;
    logic                   ent_valid_reg;
    logic                   ent_space_reg;
    code_entry_t            ent_code_reg;
    logic [MAX_SYMBOLS-1:0] pat_reg;
    logic [2:0]             rem_reg;
    logic                   key_reg, dot_reg, dash_reg, busy_reg, done_reg, err_reg;

    logic                   rom_valid, rom_space;
    code_entry_t            rom_code;
    logic [MAX_SYMBOLS-1:0] load_pat;

    morse_code_rom u_rom (
        .ascii    (in_char),
        .valid    (rom_valid),
        .is_space (rom_space),
        .code     (rom_code)
    );

    // Left-align the pattern so the current element is always the MSB.
    always_comb begin
        load_pat = MAX_SYMBOLS'(ent_code_reg.pattern) << (MAX_SYMBOLS - int'(ent_code_reg.len));
    end

    // Countdown start value N*U-1, saturating when the product overflows the counter.
    function automatic logic [CNT_W-1:0] interval(input int units, input logic [CNT_W-1:0] u);
        logic [CNT_W+1:0] prod;
        logic [CNT_W+1:0] lim;
        prod = (CNT_W+2)'(u) * (CNT_W+2)'(units);
        lim  = (CNT_W+2)'(1) << CNT_W;
        if (prod > lim)
            return '1;
        return CNT_W'(prod - (CNT_W+2)'(1));
    endfunction

    assign in_ready   = internal_rst_n && (state_reg == ST_IDLE) && !abort;
    assign key_out    = key_reg;
    assign dot_pulse  = dot_reg;
    assign dash_pulse = dash_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;

    always_ff @(posedge clk or negedge internal_rst_n) begin
        if (!internal_rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            u_reg         <= '0;
            ent_valid_reg <= 1'b0;
            ent_space_reg <= 1'b0;
            ent_code_reg  <= '0;
            pat_reg       <= '0;
            rem_reg       <= '0;
            key_reg       <= 1'b0;
            dot_reg       <= 1'b0;
            dash_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            dot_reg  <= 1'b0;
            dash_reg <= 1'b0;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            if (abort) begin
                state_reg <= ST_IDLE;
                key_reg   <= 1'b0;
                busy_reg  <= 1'b0;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (in_valid) begin
                            state_reg     <= ST_LOAD;
                            busy_reg      <= 1'b1;
                            u_reg         <= (unit_cycles == '0) ? CNT_W'(1) : unit_cycles;
                            ent_valid_reg <= rom_valid;
                            ent_space_reg <= rom_space;
                            ent_code_reg  <= rom_code;
                            // Flag the rejection while LOAD is on the bus.
                            err_reg       <= !rom_valid;
                        end
                    end
                    ST_LOAD: begin
                        if (!ent_valid_reg) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end else if (ent_space_reg) begin
                            state_reg <= ST_WORD_GAP;
                            cnt_reg   <= interval(WORD_GAP_UNITS, u_reg);
                        end else begin
                            state_reg <= ST_MARK;
                            pat_reg   <= load_pat;
                            rem_reg   <= ent_code_reg.len - 3'd1;
                            key_reg   <= 1'b1;
                            dot_reg   <= !load_pat[MAX_SYMBOLS-1];
                            dash_reg  <= load_pat[MAX_SYMBOLS-1];
                            cnt_reg   <= interval(load_pat[MAX_SYMBOLS-1] ? DASH_UNITS : ELEM_UNITS, u_reg);
                        end
                    end
                    ST_MARK: begin
                        if (cnt_reg != '0) begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end else begin
                            key_reg <= 1'b0;
                            if (rem_reg != 3'd0) begin
                                state_reg <= ST_ELEM_GAP;
                                cnt_reg   <= interval(ELEM_UNITS, u_reg);
                            end else begin
                                state_reg <= ST_CHAR_GAP;
                                cnt_reg   <= interval(CHAR_GAP_UNITS, u_reg);
                            end
                        end
                    end
                    ST_ELEM_GAP: begin
                        if (cnt_reg != '0) begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end else begin
                            state_reg <= ST_MARK;
                            pat_reg   <= pat_reg << 1;
                            rem_reg   <= rem_reg - 3'd1;
                            key_reg   <= 1'b1;
                            dot_reg   <= !pat_reg[MAX_SYMBOLS-2];
                            dash_reg  <= pat_reg[MAX_SYMBOLS-2];
                            cnt_reg   <= interval(pat_reg[MAX_SYMBOLS-2] ? DASH_UNITS : ELEM_UNITS, u_reg);
                        end
                    end
                    ST_CHAR_GAP, ST_WORD_GAP: begin
                        if (cnt_reg != '0) begin
                            cnt_reg  <= cnt_reg - CNT_W'(1);
                            done_reg <= (cnt_reg == CNT_W'(1));
                        end else begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        key_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_char_encoder.sv
// Self-checking bench: per-cycle reference built from Morse strings, table vectors, and corner sequences.
module tb_morse_char_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = 8'h00;
    logic        in_ready;
    logic [31:0] unit_cycles = 32'd1;
    logic        abort = 1'b0;
    logic        key_out, dot_pulse, dash_pulse, busy, done, err;

    always #5 clk = ~clk;

    morse_char_encoder #(.MAX_SYMBOLS(5), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_char     (in_char),
        .in_ready    (in_ready),
        .unit_cycles (unit_cycles),
        .abort       (abort),
        .key_out     (key_out),
        .dot_pulse   (dot_pulse),
        .dash_pulse  (dash_pulse),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Observed vector: {in_ready, busy, key_out, dot_pulse, dash_pulse, done, err}
    logic [6:0] exp_q[$];
    int m_high, m_dot, m_dash, m_evt, m_err;

    string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                           ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                           "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string digits[10] = '{"-----", ".----", "..---", "...--", "....-",
                          ".....", "-....", "--...", "---..", "----."};

    typedef struct {
        logic [7:0] ch;
        int         u;
        int         high;
        int         dots;
        int         dashes;
        int         evt;
        int         is_err;
    } vec_t;
    vec_t tbl[9];

    function automatic logic [6:0] sample();
        return {in_ready, busy, key_out, dot_pulse, dash_pulse, done, err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // kind: 0 unsupported, 1 coded character, 2 word space
    function automatic string morse_of(input logic [7:0] c, output int kind);
        int f;
        f = int'(c);
        if (f >= 97 && f <= 122) f = f - 32;
        kind = 1;
        if (f >= 65 && f <= 90) return letters[f - 65];
        if (f >= 48 && f <= 57) return digits[f - 48];
        kind = (f == 32) ? 2 : 0;
        return "";
    endfunction

    task automatic build_model(input logic [7:0] c, input int u);
        int    uu, kind, n;
        string s;
        uu = (u == 0) ? 1 : u;
        s  = morse_of(c, kind);
        exp_q.delete();
        exp_q.push_back({1'b0, 1'b1, 4'b0000, (kind == 0)});
        if (kind == 1) begin
            for (int i = 0; i < s.len(); i++) begin
                n = (s[i] == 8'h2D) ? 3 : 1;
                for (int k = 0; k < n * uu; k++)
                    exp_q.push_back({1'b0, 1'b1, 1'b1, (k == 0 && n == 1), (k == 0 && n == 3), 2'b00});
                if (i < s.len() - 1)
                    for (int k = 0; k < uu; k++) exp_q.push_back(7'b0100000);
            end
            for (int k = 0; k < 3 * uu; k++)
                exp_q.push_back({1'b0, 1'b1, 3'b000, (k == 3 * uu - 1), 1'b0});
        end else if (kind == 2) begin
            for (int k = 0; k < 4 * uu; k++)
                exp_q.push_back({1'b0, 1'b1, 3'b000, (k == 4 * uu - 1), 1'b0});
        end
        exp_q.push_back(7'b1000000);
    endtask

    // Offers one character and checks every cycle from LOAD through the following idle cycle.
    task automatic run_char(input logic [7:0] c, input int u, input int mid_u, input int mid_at);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_accept", 32'(in_ready), 32'd1);
        build_model(c, u);
        in_valid    = 1'b1;
        in_char     = c;
        unit_cycles = u;
        @(negedge clk);
        in_valid = 1'b0;
        m_high = 0; m_dot = 0; m_dash = 0; m_evt = 0; m_err = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == mid_at) unit_cycles = mid_u;
            check($sformatf("char_%02h_u%0d_cyc%0d", c, u, i), 32'(sample()), 32'(exp_q[i]));
            m_high += int'(key_out);
            m_dot  += int'(dot_pulse);
            m_dash += int'(dash_pulse);
            if (done || err) m_evt = i + 1;
            if (err) m_err = 1;
            if (i != exp_q.size() - 1) @(negedge clk);
        end
        $display("char 0x%02h U=%0d: %0d cycles, high=%0d dots=%0d dashes=%0d", c, u, exp_q.size(), m_high, m_dot, m_dash);
    endtask

    initial begin
        int done_seen;
        tbl[0] = '{8'h45, 4, 4, 1, 0, 17, 0};   // E
        tbl[1] = '{8'h61, 2, 8, 1, 1, 17, 0};   // a
        tbl[2] = '{8'h41, 2, 8, 1, 1, 17, 0};   // A
        tbl[3] = '{8'h30, 1, 15, 0, 5, 23, 0};  // 0
        tbl[4] = '{8'h20, 3, 0, 0, 0, 13, 0};   // space
        tbl[5] = '{8'h23, 2, 0, 0, 0, 1, 1};    // '#'
        tbl[6] = '{8'h54, 0, 3, 0, 1, 7, 0};    // T, U=0 acts as 1
        tbl[7] = '{8'h53, 3, 9, 3, 0, 25, 0};   // S
        tbl[8] = '{8'h39, 1, 13, 1, 4, 21, 0};  // 9

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(sample()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 32'(sample()), 32'h40);

        foreach (tbl[t]) begin
            run_char(tbl[t].ch, tbl[t].u, tbl[t].u, -1);
            check($sformatf("tbl%0d_high", t), 32'(m_high), 32'(tbl[t].high));
            check($sformatf("tbl%0d_dots", t), 32'(m_dot), 32'(tbl[t].dots));
            check($sformatf("tbl%0d_dashes", t), 32'(m_dash), 32'(tbl[t].dashes));
            check($sformatf("tbl%0d_event_cycle", t), 32'(m_evt), 32'(tbl[t].evt));
            check($sformatf("tbl%0d_err", t), 32'(m_err), 32'(tbl[t].is_err));
        end

        // unit_cycles changed mid-character: current char keeps old U, next char uses new U
        run_char(8'h45, 2, 7, 2);
        run_char(8'h45, 7, 7, -1);

        // abort in IDLE blocks acceptance
        @(negedge clk);
        abort = 1'b1; in_valid = 1'b1; in_char = 8'h45; unit_cycles = 1;
        #1 check("abort_idle_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        check("abort_idle_no_accept", 32'(busy), 32'd0);
        $display("abort in idle: busy=%0d", busy);

        // abort in the 7th mark cycle of T, U=5
        in_valid = 1'b1; in_char = 8'h54; unit_cycles = 5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_mark_key", 32'(key_out), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_key_low", 32'(key_out), 32'd0);
        check("abort_busy_low", 32'(busy), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            done_seen += int'(done) + int'(err) + int'(key_out);
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        $display("abort mid-mark: key=%0d busy=%0d", key_out, busy);

        // reset asserted mid-mark clears outputs asynchronously
        in_valid = 1'b1; in_char = 8'h54; unit_cycles = 5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_key_before", 32'(key_out), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_outputs", 32'(sample()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_recover", 32'(sample()), 32'h40);
        $display("reset mid-mark: outputs cleared");

        // Randomized characters against the reference model
        for (int r = 0; r < 30; r++) begin
            logic [7:0] c;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: c = 8'(65 + $urandom_range(0, 25));
                3, 4:    c = 8'(97 + $urandom_range(0, 25));
                5, 6:    c = 8'(48 + $urandom_range(0, 9));
                7:       c = 8'h20;
                default: c = 8'($urandom_range(33, 47));
            endcase
            run_char(c, $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(1, 5));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
